// File: rtl/edge_detector_bank.sv
// Multi-channel glitch-filtered edge detector with mode-gated events, sticky flags and irq.
// Optional input synchroniser compiled in with `define EDGE_BANK_SYNC_EN.
module edge_detector_bank #(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHANNELS-1:0]     signal_in,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [FILTER_W-1:0]     filter_len,
    input  logic [CHANNELS-1:0]     clear,
    output logic [CHANNELS-1:0]     level_out,
    output logic [CHANNELS-1:0]     rising_edge,
    output logic [CHANNELS-1:0]     falling_edge,
    output logic [CHANNELS-1:0]     event_pulse,
    output logic [CHANNELS-1:0]     event_sticky,
    output logic                    irq
);

    logic [CHANNELS-1:0] s;

`ifdef EDGE_BANK_SYNC_EN
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= signal_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    assign s = signal_in;
`endif

    logic [FILTER_W-1:0] cnt_q [CHANNELS];
    logic [FILTER_W-1:0] cnt_d [CHANNELS];
    logic [CHANNELS-1:0] lvl_q, lvl_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] sticky_q, sticky_d;

    always_comb begin
        lvl_d  = lvl_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filter_len) begin
                // >= so a lowered filter_len commits immediately instead of wrapping
                lvl_d[i]  = s[i];
                cnt_d[i]  = '0;
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + FILTER_W'(1);
            end
        end
    end

    always_comb begin
        event_pulse = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            event_pulse[i] = (rise_q[i] & mode[2*i]) | (fall_q[i] & mode[2*i+1]);
        end
        // Set wins over a simultaneous clear
        sticky_d = (sticky_q & ~clear) | event_pulse;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= '0;
            end
            lvl_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            lvl_q    <= lvl_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign level_out    = lvl_q;
    assign rising_edge  = rise_q;
    assign falling_edge = fall_q;
    assign event_sticky = sticky_q;
    assign irq          = |sticky_q;

endmodule

// File: tb/tb_edge_detector_bank.sv
// Self-checking bench for edge_detector_bank: directed scenarios plus randomized traffic
// compared against a run-length reference model.
module tb_edge_detector_bank;

    localparam int unsigned CH = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned FW = 4;
`ifdef EDGE_BANK_SYNC_EN
    localparam int S = SYNC;
`else
    localparam int S = 0;
`endif
    localparam int SIDX = (S == 0) ? 0 : S - 1;

    logic           clk;
    logic           rst_n;
    logic [CH-1:0]  signal_in;
    logic [2*CH-1:0] mode;
    logic [FW-1:0]  filter_len;
    logic [CH-1:0]  clear;
    logic [CH-1:0]  level_out;
    logic [CH-1:0]  rising_edge;
    logic [CH-1:0]  falling_edge;
    logic [CH-1:0]  event_pulse;
    logic [CH-1:0]  event_sticky;
    logic           irq;

    edge_detector_bank #(
        .CHANNELS   (CH),
        .SYNC_STAGES(SYNC),
        .FILTER_W   (FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal_in   (signal_in),
        .mode        (mode),
        .filter_len  (filter_len),
        .clear       (clear),
        .level_out   (level_out),
        .rising_edge (rising_edge),
        .falling_edge(falling_edge),
        .event_pulse (event_pulse),
        .event_sticky(event_sticky),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: level changes once the run of samples differing from it exceeds N.
    logic [CH-1:0] m_lvl, m_rise, m_fall, m_sticky;
    int            m_run [CH];
    logic [CH-1:0] m_pipe [SYNC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] exp_ep();
        logic [CH-1:0] ep;
        for (int i = 0; i < int'(CH); i++) begin
            ep[i] = (m_rise[i] & mode[2*i]) | (m_fall[i] & mode[2*i+1]);
        end
        return ep;
    endfunction

    task automatic model_reset();
        m_lvl = '0;
        m_rise = '0;
        m_fall = '0;
        m_sticky = '0;
        for (int i = 0; i < int'(CH); i++) m_run[i] = 0;
        for (int k = 0; k < int'(SYNC); k++) m_pipe[k] = '0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_level"}, 32'(level_out), 32'(m_lvl));
        check({tag, "_rise"}, 32'(rising_edge), 32'(m_rise));
        check({tag, "_fall"}, 32'(falling_edge), 32'(m_fall));
        check({tag, "_event"}, 32'(event_pulse), 32'(exp_ep()));
        check({tag, "_sticky"}, 32'(event_sticky), 32'(m_sticky));
        check({tag, "_irq"}, 32'(irq), 32'(|m_sticky));
    endtask

    task automatic tick(input string tag);
        logic [CH-1:0] s;
        m_sticky = (m_sticky & ~clear) | exp_ep();
        s = (S == 0) ? signal_in : m_pipe[SIDX];
        for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = signal_in;
        for (int i = 0; i < int'(CH); i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (s[i] == m_lvl[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] > int'(filter_len)) begin
                    m_lvl[i]  = s[i];
                    m_run[i]  = 0;
                    m_rise[i] = s[i];
                    m_fall[i] = ~s[i];
                end
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic       rise_seen;
        logic       fall_seen;
        logic       found;
        signal_in  = 8'h01;
        mode       = '0;
        filter_len = '0;
        clear      = '0;
        rst_n      = 1'b0;
        model_reset();

        // Input held high through reset produces one rising pulse after release
        apply_reset("t1_reset");
        for (int k = 0; k < 6; k++) begin
            tick("t1");
            check("t1_rise0", 32'(rising_edge[0]), 32'(k == S));
            check("t1_rise_others", 32'(rising_edge[7:1]), 32'(0));
        end

        // A 3-sample glitch with N=3 is rejected; 4 samples are accepted
        signal_in  = '0;
        filter_len = 4'd3;
        for (int k = 0; k < S + 6; k++) tick("t2_settle");
        signal_in[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("t2_glitch");
            seen |= rising_edge[1];
        end
        signal_in[1] = 1'b0;
        for (int k = 0; k < S + 6; k++) begin
            tick("t2_glitch");
            seen |= rising_edge[1];
        end
        check("t2_no_rise", 32'(seen), 32'(0));
        check("t2_level_low", 32'(level_out[1]), 32'(0));
        signal_in[1] = 1'b1;
        for (int k = 0; k < S + 6; k++) begin
            tick("t2_hold");
            check("t2_rise1", 32'(rising_edge[1]), 32'(k == S + 3));
        end
        check("t2_level_high", 32'(level_out[1]), 32'(1));

        // Rising-only mode on ch2 with a square wave
        filter_len = 4'd0;
        mode       = 16'h0010;
        clear      = '1;
        tick("t3_clr");
        clear      = '0;
        rise_seen  = 1'b0;
        fall_seen  = 1'b0;
        for (int k = 0; k < 10 + S; k++) begin
            signal_in[2] = ~signal_in[2];
            tick("t3_sq");
            rise_seen |= rising_edge[2];
            fall_seen |= falling_edge[2];
            check("t3_ep_no_fall", 32'(event_pulse[2] & falling_edge[2]), 32'(0));
        end
        check("t3_rise_seen", 32'(rise_seen), 32'(1));
        check("t3_fall_seen", 32'(fall_seen), 32'(1));
        check("t3_sticky2", 32'(event_sticky[2]), 32'(1));
        check("t3_irq", 32'(irq), 32'(1));

        // Clear coincident with a pulse loses nothing; a lone clear empties the flag
        signal_in[2] = 1'b0;
        for (int k = 0; k < S + 2; k++) tick("t4_settle");
        clear = '1;
        tick("t4_clr");
        clear = '0;
        check("t4_irq_clear", 32'(irq), 32'(0));
        signal_in[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick("t4_wait");
            found = event_pulse[2];
        end
        check("t4_pulse_found", 32'(found), 32'(1));
        clear[2] = 1'b1;
        tick("t4_same");
        check("t4_set_wins", 32'(event_sticky[2]), 32'(1));
        tick("t4_next");
        check("t4_cleared", 32'(event_sticky[2]), 32'(0));
        check("t4_irq_low", 32'(irq), 32'(0));
        clear = '0;

        // Lowering filter_len below a pending count commits on the next differing sample
        mode = '0;
        filter_len = 4'd7;
        signal_in[4] = 1'b1;
        for (int k = 0; k < S + 5; k++) tick("t5_count");
        check("t5_still_low", 32'(level_out[4]), 32'(0));
        filter_len = 4'd2;
        tick("t5_commit");
        check("t5_level", 32'(level_out[4]), 32'(1));
        check("t5_rise", 32'(rising_edge[4]), 32'(1));
        signal_in[4] = 1'b0;
        for (int k = 0; k < S + 5; k++) begin
            tick("t5_back");
            check("t5_fall4", 32'(falling_edge[4]), 32'(k == S + 2));
        end

        // Reset mid-count discards the pending transition
        filter_len = 4'd3;
        signal_in[3] = 1'b1;
        for (int k = 0; k < S + 2; k++) tick("t6_count");
        apply_reset("t6_reset");
        for (int k = 0; k < S + 6; k++) begin
            tick("t6_after");
            check("t6_rise3", 32'(rising_edge[3]), 32'(k == S + 3));
        end

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            signal_in = signal_in ^ CH'($urandom & $urandom & $urandom);
            clear = CH'($urandom & $urandom);
            if (k % 16 == 0) begin
                mode = 16'($urandom);
                #1;
                check("rnd_ep_mode", 32'(event_pulse), 32'(exp_ep()));
            end
            if (k % 25 == 0) filter_len = FW'($urandom_range(0, 3));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
